// File: rtl/msg_pkg.sv
// ---------------------------------------------------------------------------
// msg_pkg
// Shared definitions for the framed message packer and its receive-side
// counterpart: FSM state encoding, default sync word, header geometry and
// the header byte index constants.
// ---------------------------------------------------------------------------
package msg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_HDR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } msg_state_e;

    localparam logic [15:0] SYNC_DEFAULT = 16'hEB90;
    localparam int          HDR_BYTES    = 6;

    // Position of each byte inside the 6-byte header.
    localparam logic [2:0] HDR_IDX_SYNC_HI = 3'd0;
    localparam logic [2:0] HDR_IDX_SYNC_LO = 3'd1;
    localparam logic [2:0] HDR_IDX_SEQ     = 3'd2;
    localparam logic [2:0] HDR_IDX_CH      = 3'd3;
    localparam logic [2:0] HDR_IDX_LEN_HI  = 3'd4;
    localparam logic [2:0] HDR_IDX_LEN_LO  = 3'd5;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/msg_frame_packer_chk_accum.sv
// ---------------------------------------------------------------------------
// msg_chk_accum
// 8-bit wrapping running-sum accumulator. Used for frame checksum
// generation here and intended for reuse by the receive-side checker.
//
// Ports:
//   sys_clk_i  system clock
//   rst_i      asynchronous active-high reset
//   clr_i      synchronous clear to zero (has priority over en_i)
//   en_i       add data_i to the running sum
//   data_i     byte to accumulate
//   sum_o      current running sum
// ---------------------------------------------------------------------------
module msg_chk_accum (
    input  logic       sys_clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_o <= 8'h00;
        end else if (clr_i) begin
            sum_o <= 8'h00;
        end else if (en_i) begin
            sum_o <= sum_o + data_i;
        end
    end

endmodule

// File: rtl/msg_frame_packer.sv
// ---------------------------------------------------------------------------
// msg_frame_packer
// On each timing pulse, drains every channel cache in ascending order and
// streams one framed packet per channel to the upstream FIFO:
//   SYNC_HI SYNC_LO SEQ CH LEN_HI LEN_LO payload[LEN] CHK
// CHK is the 8-bit wrapping sum of SEQ, CH, LEN bytes and payload.
//
// Ports:
//   sys_clk_i             system clock (100 MHz)
//   rst_i                 asynchronous active-high reset
//   timing_start_pulse_i  one-cycle start pulse
//   rd_en_o               per-channel cache read enable (one-hot or zero)
//   din_i                 per-channel cache data, channel k at [8k+7:8k]
//   data_count_i          per-channel fill level, channel k at [16k+15:16k]
//   empty_i               per-channel cache empty
//   us_wr_clk_o           upstream write clock (= sys_clk_i)
//   us_wr_en_o            upstream write strobe
//   us_wr_dout_o          upstream byte
//   us_prog_full_i        upstream programmable full (>= 2 entries margin)
//   busy_o                high from pulse acceptance to last channel done
//   frame_done_pulse_o    one-cycle completion pulse
//   seq_o                 sequence number of current / last cycle
//   overrun_cnt_o         saturating count of pulses seen while busy
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a start pulse
// LATCH    | capture LEN for the current channel, clear checksum
// HDR      | emit the 6 header bytes, stalling on prog_full
// PAYLOAD  | request LEN cache bytes, forward each one cycle later
// CHK      | emit checksum byte
// NEXT     | advance to next channel or finish
// DONE     | completion pulse, drop busy
//
// Strobes towards the caches and the upstream FIFO are decoded from the
// registered state in the same cycle so prog_full gates them without a
// cycle of lag and cache data can be forwarded the cycle it is valid.
// ---------------------------------------------------------------------------
module msg_frame_packer
    import msg_pkg::*;
#(
    parameter int          CH_NUM      = 4,
    parameter int          MAX_PAYLOAD = 1024,
    parameter logic [15:0] SYNC_WORD   = SYNC_DEFAULT,
    parameter bit          EMIT_EMPTY  = 1'b1
) (
    input  logic                   sys_clk_i,
    input  logic                   rst_i,
    input  logic                   timing_start_pulse_i,
    output logic [CH_NUM-1:0]      rd_en_o,
    input  logic [CH_NUM*8-1:0]    din_i,
    input  logic [CH_NUM*16-1:0]   data_count_i,
    input  logic [CH_NUM-1:0]      empty_i,
    output logic                   us_wr_clk_o,
    output logic                   us_wr_en_o,
    output logic [7:0]             us_wr_dout_o,
    input  logic                   us_prog_full_i,
    output logic                   busy_o,
    output logic                   frame_done_pulse_o,
    output logic [7:0]             seq_o,
    output logic [15:0]            overrun_cnt_o
);

    localparam int          CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
    localparam logic [2:0]  HDR_LAST = 3'(HDR_BYTES - 1);

    msg_state_e      state;
    logic [CH_W-1:0] ch;
    logic [15:0]     len;
    logic [15:0]     req_left;
    logic [15:0]     wr_left;
    logic [2:0]      hdr_idx;
    logic            rd_pend;

    logic [7:0]      din_sel;
    logic [15:0]     cnt_sel;
    logic [15:0]     latch_len;
    logic [7:0]      hdr_byte;
    logic            rd_req;
    logic            acc_clr;
    logic            acc_en;
    logic [7:0]      chk_sum;

    assign us_wr_clk_o = sys_clk_i;

    assign din_sel = din_i[{ch, 3'b000} +: 8];
    assign cnt_sel = data_count_i[{ch, 4'b0000} +: 16];

    always_comb begin
        latch_len = cnt_sel;
        if (empty_i[ch]) begin
            latch_len = 16'd0;
        end else if (cnt_sel > MAX_LEN) begin
            latch_len = MAX_LEN;
        end
    end

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            HDR_IDX_SYNC_HI: hdr_byte = SYNC_WORD[15:8];
            HDR_IDX_SYNC_LO: hdr_byte = SYNC_WORD[7:0];
            HDR_IDX_SEQ:     hdr_byte = seq_o;
            HDR_IDX_CH:      hdr_byte = 8'(ch);
            HDR_IDX_LEN_HI:  hdr_byte = len[15:8];
            HDR_IDX_LEN_LO:  hdr_byte = len[7:0];
            default:         hdr_byte = 8'h00;
        endcase
    end

    // A new request is only issued while the upstream FIFO has room; the
    // byte it returns is always written, relying on the prog_full margin.
    assign rd_req = (state == ST_PAYLOAD) && !us_prog_full_i && (req_left != 16'd0);

    always_comb begin
        rd_en_o = '0;
        if (rd_req) begin
            rd_en_o = CH_NUM'(1) << ch;
        end
    end

    always_comb begin
        us_wr_en_o   = 1'b0;
        us_wr_dout_o = 8'h00;
        acc_en       = 1'b0;
        case (state)
            ST_HDR: begin
                if (!us_prog_full_i) begin
                    us_wr_en_o   = 1'b1;
                    us_wr_dout_o = hdr_byte;
                    // sync bytes are excluded from the checksum
                    acc_en       = (hdr_idx >= HDR_IDX_SEQ);
                end
            end
            ST_PAYLOAD: begin
                if (rd_pend) begin
                    us_wr_en_o   = 1'b1;
                    us_wr_dout_o = din_sel;
                    acc_en       = 1'b1;
                end
            end
            ST_CHK: begin
                if (!us_prog_full_i) begin
                    us_wr_en_o   = 1'b1;
                    us_wr_dout_o = chk_sum;
                end
            end
            default: ;
        endcase
    end

    assign acc_clr = (state == ST_LATCH);

    msg_chk_accum u_chk_accum (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .clr_i     (acc_clr),
        .en_i      (acc_en),
        .data_i    (us_wr_dout_o),
        .sum_o     (chk_sum)
    );

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= ST_IDLE;
            ch                 <= '0;
            len                <= 16'd0;
            req_left           <= 16'd0;
            wr_left            <= 16'd0;
            hdr_idx            <= 3'd0;
            rd_pend            <= 1'b0;
            busy_o             <= 1'b0;
            frame_done_pulse_o <= 1'b0;
            seq_o              <= 8'h00;
            overrun_cnt_o      <= 16'h0000;
        end else begin
            rd_pend <= 1'b0;

            // Pulses outside IDLE (including DONE) are dropped and counted.
            if (timing_start_pulse_i && (state != ST_IDLE)) begin
                overrun_cnt_o <= sat_inc16(overrun_cnt_o);
            end

            case (state)
                ST_IDLE: begin
                    frame_done_pulse_o <= 1'b0;
                    if (timing_start_pulse_i) begin
                        state  <= ST_LATCH;
                        busy_o <= 1'b1;
                        ch     <= '0;
                        seq_o  <= seq_o + 8'd1;
                    end
                end

                ST_LATCH: begin
                    len      <= latch_len;
                    req_left <= latch_len;
                    wr_left  <= latch_len;
                    hdr_idx  <= 3'd0;
                    if ((latch_len == 16'd0) && !EMIT_EMPTY) begin
                        state <= ST_NEXT;
                    end else begin
                        state <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    if (!us_prog_full_i) begin
                        if (hdr_idx == HDR_LAST) begin
                            state <= (len == 16'd0) ? ST_CHK : ST_PAYLOAD;
                        end else begin
                            hdr_idx <= hdr_idx + 3'd1;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    rd_pend <= rd_req;
                    if (rd_req) begin
                        req_left <= req_left - 16'd1;
                    end
                    if (rd_pend) begin
                        wr_left <= wr_left - 16'd1;
                        if (wr_left == 16'd1) begin
                            state <= ST_CHK;
                        end
                    end
                end

                ST_CHK: begin
                    if (!us_prog_full_i) begin
                        state <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    if (ch == CH_LAST) begin
                        state              <= ST_DONE;
                        frame_done_pulse_o <= 1'b1;
                        busy_o             <= 1'b0;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ST_LATCH;
                    end
                end

                ST_DONE: begin
                    frame_done_pulse_o <= 1'b0;
                    state              <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_frame_packer.sv
// Two packers share stimulus: index 0 emits empty frames, index 1 skips them.
// Each has its own cache model; expected bytes are queued before each pulse.
module tb_msg_frame_packer;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pf = 1'b0;

    logic [1:0]  rd_en   [2];
    logic [15:0] din     [2];
    logic [31:0] dcount  [2];
    logic [1:0]  empty   [2];
    logic        wr_clk  [2];
    logic        wr_en   [2];
    logic [7:0]  wr_dout [2];
    logic        busy    [2];
    logic        done    [2];
    logic [7:0]  seq     [2];
    logic [15:0] ovr     [2];

    logic [7:0]  mem [2][2][4096];
    int          wp  [2][2];
    int          rp  [2][2];

    byte_q_t     expq [2];
    int          rd_cnt   [2];
    int          done_cnt [2];
    int          exp_done [2];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_seq = 8'd0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        msg_frame_packer #(
            .CH_NUM      (2),
            .MAX_PAYLOAD (1024),
            .SYNC_WORD   (16'hEB90),
            .EMIT_EMPTY  (g == 0)
        ) u_dut (
            .sys_clk_i            (clk),
            .rst_i                (rst),
            .timing_start_pulse_i (start),
            .rd_en_o              (rd_en[g]),
            .din_i                (din[g]),
            .data_count_i         (dcount[g]),
            .empty_i              (empty[g]),
            .us_wr_clk_o          (wr_clk[g]),
            .us_wr_en_o           (wr_en[g]),
            .us_wr_dout_o         (wr_dout[g]),
            .us_prog_full_i       (pf),
            .busy_o               (busy[g]),
            .frame_done_pulse_o   (done[g]),
            .seq_o                (seq[g]),
            .overrun_cnt_o        (ovr[g])
        );
    end

    // Cache model: registered read data, valid the cycle after rd_en.
    initial begin
        for (int d = 0; d < 2; d++) begin
            din[d] = 16'h0000;
            for (int k = 0; k < 2; k++) begin
                wp[d][k] = 0;
                rp[d][k] = 0;
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                if (rd_en[d][k]) begin
                    din[d][k*8 +: 8] <= mem[d][k][rp[d][k] % 4096];
                    rp[d][k]         <= rp[d][k] + 1;
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            dcount[d] = 32'h0;
            empty[d]  = 2'b00;
            for (int k = 0; k < 2; k++) begin
                dcount[d][k*16 +: 16] = 16'(wp[d][k] - rp[d][k]);
                empty[d][k]           = (wp[d][k] == rp[d][k]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every upstream write.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_en[d] === 1'b1) begin
                n_checks++;
                assert (expq[d].size() != 0) else begin
                    n_errors++;
                    $error("FAIL stream%0d extra byte observed=%02h expected=none", d, wr_dout[d]);
                end
                if (expq[d].size() != 0) begin
                    check($sformatf("stream%0d", d), 32'(wr_dout[d]), 32'(expq[d].pop_front()));
                end
            end
            if ($countones(rd_en[d]) > 1) begin
                check($sformatf("rd_en_onehot%0d", d), 32'(rd_en[d]), 32'h1);
            end
            rd_cnt[d] = rd_cnt[d] + $countones(rd_en[d]);
            if (done[d] === 1'b1) begin
                done_cnt[d] = done_cnt[d] + 1;
            end
        end
    end

    task automatic load(input int k, input int n, input logic [7:0] base, input logic [7:0] step);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < n; i++) begin
                mem[d][k][(wp[d][k] + i) % 4096] = base + 8'(i) * step;
            end
            wp[d][k] = wp[d][k] + n;
        end
    endtask

    // Reference frame builder from the bench's own cache contents.
    task automatic push_frames(input logic [7:0] s);
        for (int d = 0; d < 2; d++) begin
            exp_done[d] = exp_done[d] + 1;
            for (int k = 0; k < 2; k++) begin
                int         n;
                int         ln;
                logic [7:0] sum;
                logic [7:0] b;
                n  = wp[d][k] - rp[d][k];
                ln = (n > 1024) ? 1024 : n;
                if (!(ln == 0 && d == 1)) begin
                    expq[d].push_back(8'hEB);
                    expq[d].push_back(8'h90);
                    expq[d].push_back(s);
                    expq[d].push_back(8'(k));
                    expq[d].push_back(8'(ln >> 8));
                    expq[d].push_back(8'(ln));
                    sum = s + 8'(k) + 8'(ln >> 8) + 8'(ln);
                    for (int i = 0; i < ln; i++) begin
                        b = mem[d][k][(rp[d][k] + i) % 4096];
                        expq[d].push_back(b);
                        sum = sum + b;
                    end
                    expq[d].push_back(sum);
                end
            end
        end
    endtask

    task automatic pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while ((done_cnt[0] < exp_done[0] || done_cnt[1] < exp_done[1]) && cyc < 6000) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, 32'(cyc < 6000), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_done_cnt%0d", tag, d), 32'(done_cnt[d]), 32'(exp_done[d]));
            check($sformatf("%s_busy%0d", tag, d), 32'(busy[d]), 32'h0);
            check($sformatf("%s_queue%0d", tag, d), 32'(expq[d].size()), 32'h0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en[0]), 32'h0);
        check({tag, "_wr_en"}, 32'(wr_en[0]), 32'h0);
        check({tag, "_dout"}, 32'(wr_dout[0]), 32'h0);
        check({tag, "_busy"}, 32'(busy[0]), 32'h0);
        check({tag, "_done"}, 32'(done[0]), 32'h0);
        check({tag, "_seq"}, 32'(seq[0]), 32'h0);
        check({tag, "_ovr"}, 32'(ovr[0]), 32'h0);
        check({tag, "_busy_skip"}, 32'(busy[1]), 32'h0);
    endtask

    initial begin
        int base;
        int cyc;
        int dc;
        for (int d = 0; d < 2; d++) begin
            rd_cnt[d]   = 0;
            done_cnt[d] = 0;
            exp_done[d] = 0;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // A: ch0 = 11 22 33, ch1 empty; also check pulse-to-write latency
        load(0, 3, 8'h11, 8'h11);
        exp_seq = exp_seq + 8'd1;
        push_frames(exp_seq);
        pulse();
        check("lat_latch_wr_en", 32'(wr_en[0]), 32'h0);
        check("lat_latch_busy", 32'(busy[0]), 32'h1);
        @(posedge clk); #1;
        check("lat_first_wr_en", 32'(wr_en[0]), 32'h1);
        check("lat_first_byte", 32'(wr_dout[0]), 32'hEB);
        wait_done("a");
        check("a_seq", 32'(seq[0]), 32'h01);

        // B: second pulse 10 cycles after the first is dropped and counted
        load(0, 3, 8'h44, 8'h11);
        load(1, 1, 8'hA5, 8'h00);
        exp_seq = exp_seq + 8'd1;
        push_frames(exp_seq);
        pulse();
        repeat (8) @(posedge clk);
        pulse();
        check("ovr_busy", 32'(busy[0]), 32'h1);
        check("ovr_cnt", 32'(ovr[0]), 32'h1);
        check("ovr_cnt_skip", 32'(ovr[1]), 32'h1);
        wait_done("b");
        check("b_seq", 32'(seq[0]), 32'(exp_seq));

        // C: prog_full held for 5 cycles in the middle of a payload
        load(0, 12, 8'h07, 8'h13);
        load(1, 2, 8'hC0, 8'h01);
        exp_seq = exp_seq + 8'd1;
        push_frames(exp_seq);
        base = rd_cnt[0];
        pulse();
        cyc = 0;
        while (rd_cnt[0] < base + 3 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("stall_reach_timeout", 32'(cyc < 200), 32'h1);
        pf = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_rd_en_c%0d", i), 32'(rd_en[0]), 32'h0);
            if (i > 0) begin
                check($sformatf("stall_wr_en_c%0d", i), 32'(wr_en[0]), 32'h0);
            end
            @(posedge clk); #1;
        end
        pf = 1'b0;
        wait_done("c");

        // D: 2000 bytes clipped to 1024; remainder stays in the cache
        load(0, 2000, 8'h03, 8'h07);
        exp_seq = exp_seq + 8'd1;
        push_frames(exp_seq);
        base = rd_cnt[0];
        pulse();
        wait_done("d");
        check("d_rd_pulses", 32'(rd_cnt[0] - base), 32'd1024);
        check("d_remaining", 32'(dcount[0][15:0]), 32'd976);

        // E: reset in the middle of a payload, then restart
        exp_seq = exp_seq + 8'd1;
        push_frames(exp_seq);
        base = rd_cnt[0];
        pulse();
        check("e_seq", 32'(seq[0]), 32'(exp_seq));
        cyc = 0;
        while (rd_cnt[0] < base + 5 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("e_reach_timeout", 32'(cyc < 200), 32'h1);
        dc = done_cnt[0];
        rst = 1'b1;
        #1;
        check_zero_outputs("e_rst");
        repeat (3) @(posedge clk);
        #1;
        check("e_no_done", 32'(done_cnt[0]), 32'(dc));
        check("e_rst_held_busy", 32'(busy[0]), 32'h0);
        for (int d = 0; d < 2; d++) begin
            expq[d].delete();
            exp_done[d] = done_cnt[d];
        end
        rst = 1'b0;
        exp_seq = 8'd1;
        push_frames(exp_seq);
        pulse();
        check("e_restart_seq", 32'(seq[0]), 32'h01);
        check("e_restart_ovr", 32'(ovr[0]), 32'h0);
        wait_done("e");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
